// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the iterative key schedule:
// S-box table, round constants, 32-bit word type and word-level functions.
package aes_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  sbox_t [256];
    typedef logic [7:0]  rcon_t [0:10];

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } ks_state_t;

    localparam sbox_t SBOX = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 is never used: round 1 is the first expansion.
    localparam rcon_t RCON = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup, one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/keyexpansion.sv
// Iterative AES-128 key schedule: one registered round key per cycle, period R+1.
// Optional build macro KEYEXP_LAST_FLAG_EN adds the registered last_o flag.
module keyexpansion
    import aes_pkg::*;
#(
    parameter int R = 10,
    parameter int N = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         key_i,
    output logic [N-1:0]         key_o,
    output logic [$clog2(R)-1:0] roundnum
`ifdef KEYEXP_LAST_FLAG_EN
    ,
    output logic                 last_o
`endif
);

    localparam int             RW     = $clog2(R);
    localparam logic [RW-1:0] R_LAST = RW'(R);

    ks_state_t      state_q, state_d;
    logic [N-1:0]   key_q, key_d;
    logic [RW-1:0]  round_q, round_d;

    word_t w0, w1, w2, w3;
    word_t rot_w, sub_w, t_w;
    word_t n0, n1, n2, n3;
    logic [7:0] rcon;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*i +: 8]),
            .out_byte (sub_w[8*i +: 8])
        );
    end

    // The constant for the key being produced is RCON[round_q+1]; unused at the wrap.
    assign rcon = (round_q < R_LAST) ? RCON[int'(round_q) + 1] : 8'h00;
    assign t_w  = sub_w ^ {rcon, 24'h0};
    assign n0   = w0 ^ t_w;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            ST_LOAD: begin
                key_d   = key_i;
                round_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (round_q == R_LAST) begin
                    key_d   = key_i;
                    round_d = '0;
                end else begin
                    key_d   = {n0, n1, n2, n3};
                    round_d = round_q + 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Reset is synchronous and active-high despite the rst_n name.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only.
        if (rst_n) begin
            state_q <= ST_LOAD;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign key_o    = key_q;
    assign roundnum = round_q;

`ifdef KEYEXP_LAST_FLAG_EN
    logic last_q, last_d;

    assign last_d = (round_d == R_LAST);

    always_ff @(posedge clk) begin
        if (rst_n) last_q <= 1'b0;
        else       last_q <= last_d;
    end

    assign last_o = last_q;
`endif

endmodule

// File: tb/tb_keyexpansion.sv
// Self-checking bench for keyexpansion against a FIPS-197 word-level key schedule
// model whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_keyexpansion;

    localparam int R = 10;
    localparam int N = 128;

    localparam logic [127:0] KEY_A   = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] KEY_A1  = 128'hdc9037b09b49dfe997fe723f388115a7;
    localparam logic [127:0] KEY_A10 = 128'hb48ef352ba98134e7f4d592086261876;
    localparam logic [127:0] KEY_F   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_F1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_F10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   key_i;
    logic [N-1:0]   key_o;
    logic [3:0]     roundnum;
`ifdef KEYEXP_LAST_FLAG_EN
    logic           last_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbox_m [256];

    keyexpansion #(.R(R), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_i    (key_i),
        .key_o    (key_o),
        .roundnum (roundnum)
`ifdef KEYEXP_LAST_FLAG_EN
        ,
        .last_o   (last_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 word recurrence: w[i] = w[i-4] ^ f(w[i-1]).
    function automatic logic [127:0] round_key(input logic [127:0] base, input int r);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        for (int j = 0; j < 4; j++) w[j] = base[127-32*j -: 32];
        for (int i = 4; i < 4*r + 4; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                        sbox_m[temp[15:8]], sbox_m[temp[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [127:0] base, input int r);
        check($sformatf("%s_round%0d_num", tag, r), 128'(roundnum), 128'(r));
        check($sformatf("%s_round%0d_key", tag, r), key_o, round_key(base, r));
`ifdef KEYEXP_LAST_FLAG_EN
        check($sformatf("%s_round%0d_last", tag, r), 128'(last_o), 128'(r == R));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_key"}, key_o, 128'h0);
        check({tag, "_num"}, 128'(roundnum), 128'h0);
`ifdef KEYEXP_LAST_FLAG_EN
        check({tag, "_last"}, 128'(last_o), 128'h0);
`endif
    endtask

    initial begin
        logic [127:0] new_key;
        int           junk_at;

        build_sbox();
        rst_n = 1'b1;
        key_i = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) step();
        check_reset_state("reset");

        // Directed key, first load after reset release.
        key_i = KEY_A;
        rst_n = 1'b0;
        step();
        check_cycle("a", KEY_A, 0);
        check("a_load_is_key_i", key_o, KEY_A);
        for (int r = 1; r <= R; r++) begin
            step();
            check_cycle("a", KEY_A, r);
            if (r == 1)  check("a_const_r1", key_o, KEY_A1);
            if (r == R)  check("a_const_r10", key_o, KEY_A10);
        end

        // Wrap reloads; key_i changed at round 5 must only matter at the next wrap.
        step();
        check_cycle("wrap_a", KEY_A, 0);
        for (int r = 1; r <= R; r++) begin
            step();
            check_cycle("wrap_a", KEY_A, r);
            if (r == 5) key_i = KEY_F;
        end
        step();
        check_cycle("f", KEY_F, 0);
        check("f_wrap_is_key_i", key_o, KEY_F);
        for (int r = 1; r <= R; r++) begin
            step();
            check_cycle("f", KEY_F, r);
            if (r == 1)  check("f_const_r1", key_o, KEY_F1);
            if (r == R)  check("f_const_r10", key_o, KEY_F10);
        end

        // Random keys with junk applied to key_i mid-period.
        for (int p = 0; p < 6; p++) begin
            new_key = {$urandom, $urandom, $urandom, $urandom};
            key_i   = new_key;
            junk_at = $urandom_range(1, 9);
            step();
            check_cycle($sformatf("rnd%0d", p), new_key, 0);
            for (int r = 1; r <= R; r++) begin
                step();
                check_cycle($sformatf("rnd%0d", p), new_key, r);
                if (r == junk_at) key_i = {$urandom, $urandom, $urandom, $urandom};
            end
        end

        // Reset asserted mid-run at round 6, then reload.
        new_key = {$urandom, $urandom, $urandom, $urandom};
        key_i   = new_key;
        step();
        check_cycle("mid", new_key, 0);
        for (int r = 1; r <= 6; r++) begin
            step();
            check_cycle("mid", new_key, r);
        end
        rst_n = 1'b1;
        step();
        check_reset_state("mid_reset");
        new_key = {$urandom, $urandom, $urandom, $urandom};
        key_i   = new_key;
        rst_n   = 1'b0;
        step();
        check_cycle("reload", new_key, 0);
        step();
        check_cycle("reload", new_key, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
